stopwatch_ctrl: RTL and testbench

Controller that sequences a 100 Hz timebase and a centisecond/second stopwatch count from one-cycle button pulses. The timebase is an internal prescaler that produces a single-cycle enable tick; no derived clock is used. The block owns the run/pause/lap/clear state machine and the BCD time registers. It feeds the seven-segment display driver directly.

---
 rtl/stopwatch_ctrl_if.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, run state and BCD display digits out.
// The controller takes the slave side; whatever drives the buttons takes master.
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic       tick;
    logic [1:0] state;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] csec_tens;
    logic [3:0] csec_ones;

    modport master (
        output start_stop, lap, clear,
        input  tick, state,
        input  sec_tens, sec_ones, csec_tens, csec_ones
    );

    modport slave (
        input  start_stop, lap, clear,
        output tick, state,
        output sec_tens, sec_ones, csec_tens, csec_ones
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled tick, run/pause/lap/clear FSM and
// BCD ss.cc time with a registered display that can freeze on a lap.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100,
    parameter int CNT_W   = 20
) (
    input logic            clk,
    input logic            rst,
    stopwatch_ctrl_if.slave sw
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t           st_q;
    logic [CNT_W-1:0] presc;
    logic             tick_q;
    logic [15:0]      live;
    logic [15:0]      lap_t;
    logic [15:0]      disp;

    logic             running;
    logic             wrap;
    logic [15:0]      live_nxt;

    // Packed as {sec_tens, sec_ones, csec_tens, csec_ones}; 59.99 rolls to 00.00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] st, so, ct, co;
        {st, so, ct, co} = t;
        if (co != 4'd9) begin
            co = co + 4'd1;
        end else begin
            co = 4'd0;
            if (ct != 4'd9) begin
                ct = ct + 4'd1;
            end else begin
                ct = 4'd0;
                if (so != 4'd9) begin
                    so = so + 4'd1;
                end else begin
                    so = 4'd0;
                    st = (st == 4'd5) ? 4'd0 : st + 4'd1;
                end
            end
        end
        return {st, so, ct, co};
    endfunction

    always_comb begin
        running  = (st_q == RUN) || (st_q == LAP);
        wrap     = running && (presc == LAST);
        live_nxt = wrap ? bcd_inc(live) : live;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            presc  <= '0;
            tick_q <= 1'b0;
            live   <= '0;
            lap_t  <= '0;
            disp   <= '0;
        end else begin
            tick_q <= wrap;
            if (running) presc <= wrap ? '0 : presc + 1'b1;
            live <= live_nxt;
            unique case (st_q)
                IDLE: begin
                    disp <= live_nxt;
                    if (sw.start_stop) st_q <= RUN;
                end
                RUN: begin
                    disp <= live_nxt;
                    if (sw.start_stop) begin
                        st_q <= PAUSE;
                    end else if (sw.lap) begin
                        // Capture the value before any same-edge increment.
                        st_q  <= LAP;
                        lap_t <= live;
                        disp  <= live;
                    end
                end
                LAP: begin
                    disp <= live_nxt;
                    if (sw.start_stop)  st_q <= PAUSE;
                    else if (sw.lap)    st_q <= RUN;
                    else                disp <= lap_t;
                end
                PAUSE: begin
                    disp <= live_nxt;
                    if (sw.start_stop) begin
                        st_q <= RUN;
                    end else if (sw.clear) begin
                        st_q  <= IDLE;
                        presc <= '0;
                        live  <= '0;
                        disp  <= '0;
                    end
                end
            endcase
        end
    end

    assign sw.tick      = tick_q;
    assign sw.state     = st_q;
    assign sw.sec_tens  = disp[15:12];
    assign sw.sec_ones  = disp[11:8];
    assign sw.csec_tens = disp[7:4];
    assign sw.csec_ones = disp[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and random stimulus for stopwatch_ctrl, checked against a
// model that tracks time as an integer count of centiseconds.
module tb_stopwatch_ctrl;

    localparam int DIV = 10;

    logic clk;
    logic rst;
    stopwatch_ctrl_if ifc ();

    stopwatch_ctrl #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .CNT_W  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: state code, prescaler count, time in centiseconds 0..5999.
    int m_state = 0;
    int m_pre   = 0;
    int m_time  = 0;
    int m_lap   = 0;
    int m_disp  = 0;
    int m_tick  = 0;

    function automatic logic [15:0] bcd(input int cs);
        logic [3:0] a, b, c, d;
        a = 4'(cs / 1000);
        b = 4'((cs / 100) % 10);
        c = 4'((cs / 10) % 10);
        d = 4'(cs % 10);
        return {a, b, c, d};
    endfunction

    function automatic logic [15:0] dut_disp();
        return {ifc.sec_tens, ifc.sec_ones, ifc.csec_tens, ifc.csec_ones};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit ss, input bit lp,
                         input bit cl);
        bit run;
        int old;
        if (r) begin
            m_state = 0; m_pre = 0; m_time = 0; m_lap = 0; m_tick = 0;
        end else begin
            run    = (m_state == 1) || (m_state == 3);
            m_tick = (run && m_pre == DIV - 1) ? 1 : 0;
            if (run) m_pre = m_tick ? 0 : m_pre + 1;
            old = m_time;
            if (m_tick == 1) m_time = (m_time + 1) % 6000;
            case (m_state)
                0: if (ss) m_state = 1;
                1: begin
                    if (ss) m_state = 2;
                    else if (lp) begin m_state = 3; m_lap = old; end
                end
                3: begin
                    if (ss) m_state = 2;
                    else if (lp) m_state = 1;
                end
                default: begin
                    if (ss) m_state = 1;
                    else if (cl) begin m_state = 0; m_time = 0; m_pre = 0; end
                end
            endcase
        end
        m_disp = (m_state == 3) ? m_lap : m_time;
    endtask

    task automatic step(input bit r, input bit ss, input bit lp,
                        input bit cl);
        rst = r;
        ifc.start_stop = ss;
        ifc.lap = lp;
        ifc.clear = cl;
        @(posedge clk);
        model(r, ss, lp, cl);
        @(negedge clk);
        rst = 1'b0;
        ifc.start_stop = 1'b0;
        ifc.lap = 1'b0;
        ifc.clear = 1'b0;
        cyc++;
        chk($sformatf("state@%0d", cyc), 32'(ifc.state), 32'(m_state));
        chk($sformatf("tick@%0d", cyc), 32'(ifc.tick), 32'(m_tick));
        chk($sformatf("disp@%0d", cyc), 32'(dut_disp()), 32'(bcd(m_disp)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic run_to(input string tag, input int t, input int max);
        int n;
        n = 0;
        while (m_time != t && n < max) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk(tag, 32'(dut_disp()), 32'(bcd(t)));
    endtask

    // Counts idle cycles until the DUT shows a tick, bounded.
    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            step(0, 0, 0, 0);
            n++;
        end while (ifc.tick !== 1'b1 && n < 4 * DIV);
    endtask

    initial begin
        int n;
        logic [15:0] held;
        rst = 1'b0;
        ifc.start_stop = 1'b0;
        ifc.lap = 1'b0;
        ifc.clear = 1'b0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_state", 32'(ifc.state), 32'd0);
        chk("reset_disp", 32'(dut_disp()), 32'h0);

        step(0, 1, 0, 0);
        chk("start_run", 32'(ifc.state), 32'd1);
        cycles_to_tick(n);
        chk("first_tick_period", 32'(n), 32'(DIV));
        idle(1000 - DIV);
        chk("100_ticks", 32'(dut_disp()), 32'h0100);

        idle(4);
        step(0, 1, 0, 0);
        chk("pause_state", 32'(ifc.state), 32'd2);
        held = dut_disp();
        idle(50);
        chk("pause_frozen", 32'(dut_disp()), 32'(held));
        step(0, 1, 0, 0);
        cycles_to_tick(n);
        chk("resume_partial", 32'(n), 32'd5);

        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("clear_idle", 32'(dut_disp()), 32'h0);
        step(0, 1, 0, 0);
        run_to("reach_37", 37, 1000);
        step(0, 0, 1, 0);
        chk("lap_state", 32'(ifc.state), 32'd3);
        chk("lap_disp", 32'(dut_disp()), 32'h0037);
        idle(200);
        chk("lap_frozen", 32'(dut_disp()), 32'h0037);
        step(0, 0, 1, 0);
        chk("lap_back", 32'(ifc.state), 32'd1);
        chk("live_57", 32'(dut_disp()), 32'h0057);

        step(0, 0, 0, 1);
        chk("clear_in_run", 32'(ifc.state), 32'd1);
        while (m_pre != DIV - 1) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("stop_on_tick", 32'(ifc.tick), 32'd1);
        chk("stop_on_tick_st", 32'(ifc.state), 32'd2);
        held = dut_disp();
        step(0, 1, 0, 1);
        chk("ss_beats_clear", 32'(ifc.state), 32'd1);
        chk("ss_keeps_time", 32'(dut_disp()), 32'(held));
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("clear_pause", 32'(ifc.state), 32'd0);
        chk("clear_zero", 32'(dut_disp()), 32'h0);
        step(0, 1, 0, 0);
        cycles_to_tick(n);
        chk("clear_presc0", 32'(n), 32'(DIV));

        run_to("reach_5999", 5999, 70000);
        run_to("wrap_0000", 0, 2 * DIV);

        run_to("reach_1234", 1234, 20000);
        step(0, 0, 1, 0);
        idle(7);
        step(1, 0, 0, 0);
        chk("rst_state", 32'(ifc.state), 32'd0);
        chk("rst_disp", 32'(dut_disp()), 32'h0);
        chk("rst_tick", 32'(ifc.tick), 32'd0);
        step(0, 1, 0, 0);
        cycles_to_tick(n);
        chk("rst_full_period", 32'(n), 32'(DIV));
        chk("rst_restart", 32'(dut_disp()), 32'h0001);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
